// File: rtl/register_file_pkg.sv
// register_file_pkg: shared defaults, clear-engine state type and index-width helper
// ports: none (package)
package register_file_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NUM_REGS_DEF = 32;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_file_clr_fsm.sv
// register_file_clr_fsm: sequential clear engine zeroing entries 1..NUM_REGS-1, one per cycle
// ports: clk, rst_n (async active-low); clr_req starts a clear from IDLE;
//        clr_busy high while clearing; clr_done one-cycle completion pulse;
//        clr_we/clr_idx drive the zero write into the register array
module register_file_clr_fsm
    import register_file_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    // x0 is never stored, so the sweep starts at 1 and stops at LAST without wrapping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                state_d = clr_req ? CLEAR : IDLE;
                idx_d   = FIRST;
            end
            CLEAR: begin
                state_d = (idx_q == LAST) ? DONE : CLEAR;
                idx_d   = (idx_q == LAST) ? FIRST : idx_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign clr_busy = state_q == CLEAR;
    assign clr_done = state_q == DONE;
    assign clr_we   = state_q == CLEAR;
    assign clr_idx  = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port integer register file with hardwired x0, optional bypass and sequential clear
// ports: clk, rst_n (async active-low); wr_en/wr_reg/wr_data write-back port;
//        rd_reg[p]/rd_data[p] combinational read ports; clr_req starts a clear;
//        clr_busy high while clearing; clr_done one-cycle completion pulse
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int ADDR_W       = addr_w(NUM_REGS),
    parameter int NUM_RD_PORTS = 2,
    parameter bit BYPASS       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_reg  [NUM_RD_PORTS],
    output logic [XLEN-1:0]   rd_data [NUM_RD_PORTS],
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    logic [XLEN-1:0]   mem_q [NUM_REGS];
    logic [XLEN-1:0]   mem_d [NUM_REGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;

    register_file_clr_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // the clear engine owns the array while busy, so write-back is simply shadowed
    always_comb begin
        mem_d = mem_q;
        if (clr_we)
            mem_d[clr_idx] = '0;
        else if (wr_en && wr_reg != '0)
            mem_d[wr_reg] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= '{default: '0};
        else
            mem_q <= mem_d;
    end

    // x0 masking wins over bypass; bypass is off while clearing
    always_comb begin
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p] = (rd_reg[p] == '0) ? '0
                       : (BYPASS && wr_en && !clr_busy && wr_reg == rd_reg[p]) ? wr_data
                       : mem_q[rd_reg[p]];
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: randomized and directed checks of register_file_mp against a behavioural model
`timescale 1ns/1ps
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_reg = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_reg [2];
    logic [31:0] rd_a [2];
    logic [31:0] rd_b [2];
    logic        clr_req = 1'b0;
    logic        busy_a, done_a, busy_b, done_b;

    logic        c_wr_en = 1'b0;
    logic [3:0]  c_wr_reg = '0;
    logic [63:0] c_wr_data = '0;
    logic [3:0]  c_rd_reg [4];
    logic [63:0] c_rd [4];
    logic        c_clr_req = 1'b0;
    logic        c_busy, c_done;

    always #5 clk = ~clk;

    register_file_mp dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_a), .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
    );

    register_file_mp #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_reg), .rd_data(rd_b), .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
    );

    register_file_mp #(.XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_reg(c_wr_reg), .wr_data(c_wr_data),
        .rd_reg(c_rd_reg), .rd_data(c_rd), .clr_req(c_clr_req), .clr_busy(c_busy), .clr_done(c_done)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: architectural contents plus clear progress (next entry to zero)
    logic [31:0] m_mem [32];
    bit          m_busy, m_done;
    int          m_next;

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_busy = 0;
        m_done = 0;
        m_next = 1;
    endtask

    task automatic model_edge();
        if (m_busy) begin
            m_mem[m_next] = '0;
            if (m_next == 31) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_next++;
            end
        end else begin
            if (wr_en && wr_reg != 0) m_mem[wr_reg] = wr_data;
            if (m_done) m_done = 0;
            else if (clr_req) begin
                m_busy = 1;
                m_next = 1;
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(input int p, input bit byp);
        if (rd_reg[p] == 0) return '0;
        if (byp && wr_en && !m_busy && wr_reg == rd_reg[p]) return wr_data;
        return m_mem[rd_reg[p]];
    endfunction

    // called at posedge+1 with inputs already driven; checks, then advances one clock
    task automatic cycle();
        #3;
        for (int p = 0; p < 2; p++) begin
            check("rd_byp", rd_a[p], exp_rd(p, 1));
            check("rd_nobyp", rd_b[p], exp_rd(p, 0));
        end
        check("busy_a", busy_a, m_busy);
        check("done_a", done_a, m_done);
        check("busy_b", busy_b, m_busy);
        check("done_b", done_b, m_done);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    int nb, nd;

    initial begin
        rd_reg[0] = '0;
        rd_reg[1] = '0;
        foreach (c_rd_reg[i]) c_rd_reg[i] = '0;
        model_reset();

        // reset: every index reads zero on every port
        for (int i = 0; i < 32; i++) begin
            rd_reg[0] = 5'(i);
            rd_reg[1] = 5'(31 - i);
            #1;
            check("rst_rd0", rd_a[0], 0);
            check("rst_rd1", rd_a[1], 0);
            check("rst_rdb", rd_b[0], 0);
        end
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // same-cycle write/read of x5
        wr_en = 1; wr_reg = 5; wr_data = 32'hDEADBEEF; rd_reg[0] = 5; rd_reg[1] = 0;
        #1;
        check("byp_same", rd_a[0], 32'hDEADBEEF);
        check("nobyp_same", rd_b[0], 0);
        cycle();
        wr_en = 0;
        #1;
        check("nobyp_next", rd_b[0], 32'hDEADBEEF);
        cycle();

        // x0 stays zero
        wr_en = 1; wr_reg = 0; wr_data = 32'hFFFFFFFF; rd_reg[0] = 0; rd_reg[1] = 0;
        #1;
        check("x0_a0", rd_a[0], 0);
        check("x0_a1", rd_a[1], 0);
        check("x0_b0", rd_b[0], 0);
        cycle();
        wr_en = 0;
        #1;
        check("x0_next", rd_a[1], 0);
        cycle();
        cycle();

        // 64-bit, 16-entry, 4-port instance
        c_wr_en = 1; c_wr_reg = 15; c_wr_data = 64'h0123456789ABCDEF;
        foreach (c_rd_reg[i]) c_rd_reg[i] = 4'd15;
        #1;
        for (int p = 0; p < 4; p++) check("c_byp", c_rd[p], 64'h0123456789ABCDEF);
        @(posedge clk);
        #1;
        c_wr_en = 0;
        #1;
        for (int p = 0; p < 4; p++) check("c_stored", c_rd[p], 64'h0123456789ABCDEF);
        c_clr_req = 1;
        @(posedge clk);
        #1;
        c_clr_req = 0;
        nb = 0; nd = 0;
        repeat (20) begin
            nb += int'(c_busy);
            nd += int'(c_done);
            @(posedge clk);
            #1;
        end
        check("c_busy_cycles", nb, 15);
        check("c_done_pulses", nd, 1);
        check("c_cleared", c_rd[2], 0);

        // randomized traffic with occasional clears
        for (int k = 0; k < 400; k++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_reg  = 5'($urandom);
            wr_data = $urandom;
            for (int p = 0; p < 2; p++)
                rd_reg[p] = ($urandom_range(0, 3) == 0) ? wr_reg : 5'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            cycle();
        end
        wr_en = 0; clr_req = 0;
        repeat (40) cycle();

        // fill x1..x31 with their index, then clear
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_reg = 5'(i); wr_data = i;
            cycle();
        end
        wr_en = 0;
        clr_req = 1;
        cycle();
        clr_req = 0;
        rd_reg[0] = 1; rd_reg[1] = 31;
        nb = 0; nd = 0;
        for (int k = 0; k < 40; k++) begin
            nb += int'(busy_a);
            nd += int'(done_a);
            if (k == 5) begin
                check("mid_x1", rd_a[0], 0);
                check("mid_x31", rd_a[1], 31);
            end
            wr_en = (k == 15); wr_reg = 10; wr_data = 32'h12345678;
            cycle();
        end
        wr_en = 0;
        check("busy_cycles", nb, 31);
        check("done_pulses", nd, 1);
        rd_reg[0] = 10;
        #1;
        check("x10_after", rd_a[0], 0);
        for (int i = 0; i < 32; i++) begin
            rd_reg[0] = 5'(i);
            rd_reg[1] = 5'(31 - i);
            cycle();
        end

        // reset in the middle of a clear
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_reg = 5'(i); wr_data = $urandom | 32'h1;
            cycle();
        end
        wr_en = 0;
        clr_req = 1;
        cycle();
        clr_req = 0;
        repeat (9) cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        rd_reg[0] = 31; rd_reg[1] = 20;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_x31", rd_a[0], 0);
        check("abort_x20", rd_a[1], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            nd += int'(done_a);
            rd_reg[0] = 5'(k);
            cycle();
        end
        check("abort_no_done", nd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the two-read/one-write RV32 integer register file.
- Generalised in XLEN, register count and number of read ports.
- Adds optional write-to-read bypass and a sequential clear engine that zeroes the array one entry per cycle, with a busy/done handshake.
- Sits in the decode stage of the core. Downstream reads are combinational. Write-back comes from the WB stage.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register index width; derived, never overridden.
- NUM_RD_PORTS, 2, number of independent read ports; at least 1.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored contents only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write enable.
- wr_reg  in  ADDR_W  write index.
- wr_data  in  XLEN  write data.
- rd_reg  in  NUM_RD_PORTS x ADDR_W  read indices, unpacked array.
- rd_data  out  NUM_RD_PORTS x XLEN  read data, unpacked array, combinational.
- clr_req  in  1  request a full clear; single-cycle pulse or level.
- clr_busy  out  1  clear engine active; registered.
- clr_done  out  1  one-cycle pulse on completion; registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers become 0;
  - clr_busy = 0, clr_done = 0;
  - FSM goes to IDLE, clear index goes to 1.
  - Reset asserted mid-clear aborts the clear; no clr_done pulse is produced.
- Register x0 is hardwired to zero:
  - rd_data[p] = 0 whenever rd_reg[p] == 0, regardless of wr_en or bypass;
  - writes to index 0 are dropped.
- Write path: when wr_en=1, wr_reg != 0 and clr_busy=0, wr_data is stored at the rising edge.
- Read path: rd_data[p] is mem[rd_reg[p]] combinationally. Latency is 0 cycles.
- Bypass (BYPASS=1):
  - condition: wr_en=1, wr_reg == rd_reg[p], wr_reg != 0 and clr_busy=0;
  - result: rd_data[p] = wr_data in the same cycle.
  - Applies to every matching port independently.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_req=1 at a clock edge. clr_busy rises on that edge. Index starts at 1.
  - CLEAR: each cycle mem[idx] <- 0 and idx increments. After clearing idx = NUM_REGS-1, go to DONE.
  - clr_busy is high for exactly NUM_REGS-1 cycles.
  - DONE: clr_busy=0, clr_done=1 for one cycle, then IDLE unconditionally.
  - clr_req is ignored in CLEAR and DONE, so it does not queue. A level-held clr_req re-triggers from IDLE.
- While clr_busy=1:
  - all writes are ignored;
  - bypass is suppressed;
  - reads return current array contents, so already-cleared entries read 0 and pending entries read their old values.
- Simultaneous write and clr_req in IDLE: the write commits on that edge, then the clear starts and later zeroes it.
- Index wrap: idx never wraps. The transition to DONE is taken on idx == NUM_REGS-1.
- Read ports may all address the same register; there is no port conflict.

Decomposition:
- Package register_file_pkg:
  - default XLEN and NUM_REGS constants;
  - clr_state_t enum {IDLE, CLEAR, DONE};
  - helper function addr_w(n).
- Sub-module register_file_clr_fsm:
  - owns the state register, clear index, clr_busy and clr_done;
  - outputs clr_we and clr_idx to the array.
- Top level holds the storage array, write mux (clear vs write-back), x0 masking and bypass muxes.

Test Plan:
- Reset, then read every index on both ports -> all rd_data = 0x00000000; clr_busy = 0, clr_done = 0.
- Write x5 = 0xDEADBEEF with rd_reg[0] = 5 in the same cycle:
  - BYPASS=1 -> rd_data[0] = 0xDEADBEEF in that cycle;
  - BYPASS=0 -> 0x00000000 that cycle, 0xDEADBEEF the next.
- Write x0 = 0xFFFFFFFF, then read x0 on all ports -> 0x00000000 that cycle and every following cycle.
- Fill x1..x31 with value = index, then pulse clr_req:
  - clr_busy high for exactly 31 cycles;
  - x1 reads 0 while x31 still reads 31 mid-clear;
  - clr_done is a single pulse; afterwards all registers read 0.
- During clear, write x10 = 0x12345678 after x10 has been cleared -> write ignored; x10 reads 0 after clr_done.
- Start clear, assert rst_n=0 at clear cycle 10 -> all registers 0 immediately; clr_busy = 0; no clr_done pulse; FSM in IDLE.
- NUM_RD_PORTS=4, XLEN=64, NUM_REGS=16:
  - write x15 = 0x0123456789ABCDEF;
  - all four ports reading 15 -> identical value;
  - clear takes 15 busy cycles.
